// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and entry layout for the UART receive controller.
// The FIFO entry packs the data byte with its parity and framing status bits.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_STOP = 3'd1,
    SAMPLE    = 3'd2,
    COMMIT    = 3'd3,
    CLEAR     = 3'd4
  } rx_state_e;

  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int PERR_BIT = 8;
  localparam int FERR_BIT = 9;

  function automatic logic [ENTRY_W-1:0] packEntry(input logic [7:0] data,
                                                   input logic perr,
                                                   input logic ferr);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[DATA_LSB +: 8] = data;
    e[PERR_BIT]      = perr;
    e[FERR_BIT]      = ferr;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Status-tagged receive FIFO with show-ahead read port.
// The pointers carry one extra wrap bit, so a full FIFO and an empty FIFO can be told apart.
module uart_rx_ctrl_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               push_ok_o,
  output logic [AW:0]        level_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wptr_q;
  logic [AW:0]        rptr_q;
  logic               doPush;
  logic               doPop;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign doPop     = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign doPush    = push_i && (!full_o || doPop);
  assign push_ok_o = doPush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (doPop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: stages each UART byte until its stop bit resolves, tags it, and queues it for the host.
// Optional macro UART_RX_CTRL_THRESH_IRQ_EN adds a level-threshold / idle-timeout interrupt.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int STOP_TMO = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_fifo_write_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_parity_err,
  input  logic        rx_framing_err,
  input  logic        rx_stop_strobe,
  output logic        rx_read_byte,
  output logic        rx_clear_parity,
  output logic        rx_clear_framing,
  input  logic        host_rd,
  input  logic        host_clr_ovf,
  output logic [7:0]  host_data,
  output logic        host_perr,
  output logic        host_ferr,
  output logic        rx_ready,
  output logic        fifo_full,
  output logic        overflow,
  output logic [AW:0] level,
`ifdef UART_RX_CTRL_THRESH_IRQ_EN
  input  logic [AW:0] irq_thresh,
  input  logic        irq_tmo_en,
`endif
  output logic        rx_irq
);

  localparam int TW = $clog2(STOP_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(STOP_TMO - 1);

  rx_state_e          state_q, state_d;
  logic [ENTRY_W-1:0] stage_q, stage_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               ovf_q, ovf_d;
  logic               irq_q, irqNext;
  logic               pushReq;
  logic               pushOk;
  logic               lostByte;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
      irq_q   <= irqNext;
    end
  end

  always_comb begin
    state_d          = state_q;
    stage_d          = stage_q;
    tmo_d            = tmo_q;
    pushReq          = 1'b0;
    lostByte         = 1'b0;
    rx_read_byte     = 1'b0;
    rx_clear_parity  = 1'b0;
    rx_clear_framing = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT_STOP: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_stop_strobe) begin
          state_d = SAMPLE;
        end else if (tmo_q == TMO_LAST) begin
          stage_d[FERR_BIT] = 1'b1;
          state_d           = COMMIT;
        end
      end
      // Framing status settles one cycle after the stop strobe, so it is read here.
      SAMPLE: begin
        stage_d[FERR_BIT] = rx_framing_err;
        state_d           = COMMIT;
      end
      COMMIT: begin
        pushReq = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        rx_read_byte     = 1'b1;
        rx_clear_parity  = 1'b1;
        rx_clear_framing = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new byte always wins; any byte still in flight is lost.
    if (!rx_fifo_write_n) begin
      stage_d  = packEntry(rx_byte, rx_parity_err, 1'b0);
      tmo_d    = '0;
      state_d  = WAIT_STOP;
      pushReq  = 1'b0;
      lostByte = (state_q != IDLE);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (host_clr_ovf) ovf_d = 1'b0;
    if (lostByte || (pushReq && !pushOk)) ovf_d = 1'b1;
  end

  uart_rx_ctrl_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_i   (pushReq),
    .pop_i    (host_rd),
    .wdata_i  (stage_q),
    .rdata_o  (head),
    .empty_o  (fifoEmpty),
    .full_o   (fifo_full),
    .push_ok_o(pushOk),
    .level_o  (level)
  );

  assign rx_ready  = !fifoEmpty;
  assign host_data = head[DATA_LSB +: 8];
  assign host_perr = head[PERR_BIT];
  assign host_ferr = head[FERR_BIT];
  assign overflow  = ovf_q;
  assign rx_irq    = irq_q;

`ifdef UART_RX_CTRL_THRESH_IRQ_EN
  localparam int IDLE_LIM = 4 * STOP_TMO;
  localparam int IW       = $clog2(IDLE_LIM + 1);
  localparam logic [AW:0] THRESH_MIN = 1;

  logic [IW-1:0] idle_q;
  logic [AW:0]   thresh;
  logic          activity;

  assign thresh   = (irq_thresh == '0) ? THRESH_MIN : irq_thresh;
  assign activity = pushOk || (host_rd && rx_ready);

  // Counts quiet cycles while data sits unread; saturates at the timeout limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else if (activity || !rx_ready) begin
      idle_q <= '0;
    end else if (idle_q != IW'(IDLE_LIM)) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign irqNext = (level >= thresh) || (irq_tmo_en && rx_ready && (idle_q == IW'(IDLE_LIM)));
`else
  assign irqNext = rx_ready;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized traffic against a queue model.
// Build with UART_RX_CTRL_THRESH_IRQ_EN to exercise the threshold interrupt (threshold fixed at 4).
module tb_uart_rx_ctrl;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int STOP_TMO = 150;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_fifo_write_n;
  logic [7:0]  rx_byte;
  logic        rx_parity_err;
  logic        rx_framing_err;
  logic        rx_stop_strobe;
  logic        rx_read_byte;
  logic        rx_clear_parity;
  logic        rx_clear_framing;
  logic        host_rd;
  logic        host_clr_ovf;
  logic [7:0]  host_data;
  logic        host_perr;
  logic        host_ferr;
  logic        rx_ready;
  logic        fifo_full;
  logic        overflow;
  logic [AW:0] level;
  logic        rx_irq;
`ifdef UART_RX_CTRL_THRESH_IRQ_EN
  logic [AW:0] irq_thresh = 5'd4;
  logic        irq_tmo_en = 1'b0;
`endif

  uart_rx_ctrl #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .STOP_TMO(STOP_TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_fifo_write_n (rx_fifo_write_n),
    .rx_byte         (rx_byte),
    .rx_parity_err   (rx_parity_err),
    .rx_framing_err  (rx_framing_err),
    .rx_stop_strobe  (rx_stop_strobe),
    .rx_read_byte    (rx_read_byte),
    .rx_clear_parity (rx_clear_parity),
    .rx_clear_framing(rx_clear_framing),
    .host_rd         (host_rd),
    .host_clr_ovf    (host_clr_ovf),
    .host_data       (host_data),
    .host_perr       (host_perr),
    .host_ferr       (host_ferr),
    .rx_ready        (rx_ready),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .level           (level),
`ifdef UART_RX_CTRL_THRESH_IRQ_EN
    .irq_thresh      (irq_thresh),
    .irq_tmo_en      (irq_tmo_en),
`endif
    .rx_irq          (rx_irq)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: expected FIFO contents as {ferr, perr, data} plus the sticky overflow flag.
  logic [9:0] modelQ[$];
  bit         modelOvf;

  int readPulses = 0;
  int parPulses  = 0;
  int frmPulses  = 0;
  int allPulses  = 0;

  // Handshake pulses are tallied once per cycle so their widths can be checked per frame.
  always @(negedge clk) begin
    if (rx_read_byte)     readPulses++;
    if (rx_clear_parity)  parPulses++;
    if (rx_clear_framing) frmPulses++;
    if (rx_read_byte && rx_clear_parity && rx_clear_framing) allPulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compares every host-visible status output against the model after one settling cycle.
  task automatic checkState(input string tag);
    logic [9:0] head;
    bit         expIrq;
    tick(1);
    checkOutput({tag, ".level"}, 32'(level), 32'(modelQ.size()));
    checkOutput({tag, ".ready"}, 32'(rx_ready), 32'(modelQ.size() != 0));
    checkOutput({tag, ".full"}, 32'(fifo_full), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".ovf"}, 32'(overflow), 32'(modelOvf));
`ifdef UART_RX_CTRL_THRESH_IRQ_EN
    expIrq = (modelQ.size() >= 4);
`else
    expIrq = (modelQ.size() != 0);
`endif
    checkOutput({tag, ".irq"}, 32'(rx_irq), 32'(expIrq));
    if (modelQ.size() != 0) begin
      head = modelQ[0];
      checkOutput({tag, ".data"}, 32'(host_data), 32'(head[7:0]));
      checkOutput({tag, ".perr"}, 32'(host_perr), 32'(head[8]));
      checkOutput({tag, ".ferr"}, 32'(host_ferr), 32'(head[9]));
    end
  endtask

  task automatic modelCommit(input logic [9:0] entry, input bit popNow);
    bit popped;
    popped = popNow && (modelQ.size() != 0);
    if (popped) void'(modelQ.pop_front());
    if (modelQ.size() < DEPTH) modelQ.push_back(entry);
    else modelOvf = 1'b1;
  endtask

  task automatic checkPulses(input string tag, input int r0, input int p0, input int f0, input int a0);
    checkOutput({tag, ".readPulse"}, 32'(readPulses - r0), 32'd1);
    checkOutput({tag, ".parPulse"}, 32'(parPulses - p0), 32'd1);
    checkOutput({tag, ".frmPulse"}, 32'(frmPulses - f0), 32'd1);
    checkOutput({tag, ".allPulse"}, 32'(allPulses - a0), 32'd1);
  endtask

  // One received frame: byte strobe, stop strobe after stopDelay+2 cycles, optional host pop during commit.
  // With overlap set, an earlier byte is strobed first and must be lost to the second one.
  task automatic applyStimulus(input logic [7:0] d, input bit p, input bit f, input int stopDelay,
                               input bit popAtCommit, input bit overlap);
    int r0, p0, f0, a0;
    if (overlap) begin
      rx_fifo_write_n = 1'b0;
      rx_byte         = 8'($urandom);
      rx_parity_err   = 1'($urandom);
      tick(1);
      rx_fifo_write_n = 1'b1;
      tick(3);
      modelOvf = 1'b1;
    end
    r0 = readPulses; p0 = parPulses; f0 = frmPulses; a0 = allPulses;
    rx_fifo_write_n = 1'b0;
    rx_byte         = d;
    rx_parity_err   = p;
    tick(1);
    rx_fifo_write_n = 1'b1;
    rx_byte         = 8'($urandom);
    rx_parity_err   = 1'b0;
    tick(stopDelay);
    rx_framing_err = f;
    tick(1);
    rx_stop_strobe = 1'b1;
    tick(1);
    rx_stop_strobe = 1'b0;
    tick(1);
    host_rd = popAtCommit;
    tick(1);
    host_rd = 1'b0;
    tick(1);
    rx_framing_err = 1'b0;
    modelCommit({f, p, d}, popAtCommit);
    checkPulses("frame", r0, p0, f0, a0);
  endtask

  // No stop strobe: the byte must commit exactly STOP_TMO+1 cycles after capture, marked as a framing error.
  task automatic timeoutFrame(input logic [7:0] d, input bit p);
    int          r0, p0, f0, a0;
    int          k;
    logic [AW:0] lvl0;
    r0 = readPulses; p0 = parPulses; f0 = frmPulses; a0 = allPulses;
    lvl0 = level;
    rx_fifo_write_n = 1'b0;
    rx_byte         = d;
    rx_parity_err   = p;
    tick(1);
    rx_fifo_write_n = 1'b1;
    rx_parity_err   = 1'b0;
    k = 0;
    for (int i = 1; i <= 2 * STOP_TMO; i++) begin
      tick(1);
      if (level != lvl0) begin
        k = i;
        break;
      end
    end
    checkOutput("tmo.commitDelay", 32'(k), 32'(STOP_TMO + 1));
    tick(1);
    modelCommit({1'b1, p, d}, 1'b0);
    checkPulses("tmo", r0, p0, f0, a0);
  endtask

  task automatic hostPop();
    host_rd = 1'b1;
    tick(1);
    host_rd = 1'b0;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
  endtask

  task automatic clearOverflow();
    host_clr_ovf = 1'b1;
    tick(1);
    host_clr_ovf = 1'b0;
    modelOvf = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    rx_fifo_write_n = 1'b1;
    rx_byte         = '0;
    rx_parity_err   = 1'b0;
    rx_framing_err  = 1'b0;
    rx_stop_strobe  = 1'b0;
    host_rd         = 1'b0;
    host_clr_ovf    = 1'b0;
    modelOvf        = 1'b0;
    tick(3);

    checkOutput("rst.level", 32'(level), 32'd0);
    checkOutput("rst.ready", 32'(rx_ready), 32'd0);
    checkOutput("rst.full", 32'(fifo_full), 32'd0);
    checkOutput("rst.ovf", 32'(overflow), 32'd0);
    checkOutput("rst.irq", 32'(rx_irq), 32'd0);
    checkOutput("rst.data", 32'(host_data), 32'd0);
    checkOutput("rst.flags", 32'({host_perr, host_ferr}), 32'd0);
    checkOutput("rst.pulses", 32'({rx_read_byte, rx_clear_parity, rx_clear_framing}), 32'd0);
    reset_n = 1'b1;
    tick(1);

    applyStimulus(8'hA5, 1'b0, 1'b0, 98, 1'b0, 1'b0);
    checkState("single");
    applyStimulus(8'h3C, 1'b0, 1'b1, 10, 1'b0, 1'b0);
    hostPop();
    checkState("framing");
    hostPop();
    checkState("empty");

    timeoutFrame(8'h11, 1'b1);
    checkState("timeout");
    hostPop();

    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 20), 1'b0, 1'b0);
    end
    checkState("fill");
    clearOverflow();
    checkState("clrOvf");

    applyStimulus(8'($urandom), 1'($urandom), 1'b0, 5, 1'b1, 1'b0);
    checkState("pushPopFull");

    while (modelQ.size() != 0) begin
      hostPop();
      checkState("drain");
    end
    hostPop();
    checkState("extraPop");

    applyStimulus(8'h5A, 1'b1, 1'b0, 4, 1'b0, 1'b1);
    checkState("overlap");
    clearOverflow();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1: hostPop();
        2: clearOverflow();
        default: applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 120),
                               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      endcase
      checkState("random");
    end

    rx_fifo_write_n = 1'b0;
    rx_byte         = 8'hC3;
    tick(1);
    rx_fifo_write_n = 1'b1;
    tick(5);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
    checkOutput("midRst.data", 32'(host_data), 32'd0);
    checkState("midRst");
    checkOutput("midRst.pulses", 32'({rx_read_byte, rx_clear_parity, rx_clear_framing}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
